// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_loader_pkg;

  // Loader FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Header and data words are both four little-endian bytes.
  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Index of the final byte of a word in the packer's 2-bit byte counter.
  localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Assembles four stream bytes, LSB first, into a 32-bit word.
// Serves both the header count and the instruction words.
module instr_mem_loader_byte_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q;

  // Shift each accepted byte in at the top so the first byte ends up in [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'd0;
    end else if (clear_i) begin
      cnt_q <= 2'd0;
    end else if (accept_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {byte_i, sh_q[31:8]};
    end
  end

  // The complete word is presented in the same cycle the last byte arrives.
  assign word_o       = {byte_i, sh_q[31:8]};
  assign word_valid_o = accept_i && (cnt_q == LAST_BYTE_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of the instruction memory: receives a little-endian image
// (4-byte word count, then the words), writes it from address 0 upward and
// stalls the core until the image is complete.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1; byte_i must be stable while byte_valid_i is high,
// and either side may hold its signal low for any number of cycles.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic                  ready_q, we_q, hold_q, busy_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           count_q;
  logic [ADDR_WIDTH:0]   k_q;
  logic [ADDR_WIDTH:0]   k_next;
  logic                  accept;
  logic                  start_load;
  logic                  word_valid;
  logic [31:0]           word;
  logic                  hdr_too_big;

  assign accept      = byte_valid_i && ready_q;
  assign start_load  = (state_q == S_IDLE) && start_i;
  assign k_next      = k_q + 1'b1;
  assign hdr_too_big = {1'b0, word} > CAPACITY;

  instr_mem_loader_byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_load),
    .accept_i     (accept),
    .byte_i       (byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Next-state logic; start_i is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_HDR;
      S_HDR: begin
        if (word_valid) begin
          if (word == 32'd0)    state_d = S_DONE;
          else if (hdr_too_big) state_d = S_IDLE;
          else                  state_d = S_DATA;
        end
      end
      S_DATA:  if (word_valid) state_d = S_WRITE;
      S_WRITE: state_d = (32'(k_next) == count_q) ? S_DONE : S_DATA;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs follow the next state so
  // every port comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      count_q <= 32'd0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_HDR) || (state_d == S_DATA);
      we_q    <= (state_d == S_WRITE);
      hold_q  <= (state_d != S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      if (start_load) begin
        error_q <= 1'b0;
        k_q     <= '0;
        count_q <= 32'd0;
      end
      if ((state_q == S_HDR) && word_valid) begin
        count_q <= word;
        if (hdr_too_big) error_q <= 1'b1;
      end
      // Address and data are only updated for a new write, otherwise they hold.
      if ((state_q == S_DATA) && word_valid) begin
        data_q <= word;
        addr_q <= k_q[ADDR_WIDTH-1:0];
      end
      if (state_q == S_WRITE) k_q <= k_next;
    end
  end

  assign byte_ready_o   = ready_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_data_o     = data_q;
  assign cpu_hold_o     = hold_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = k_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: one full-size instance (ADDR_WIDTH=8) and one
// tiny instance (ADDR_WIDTH=2) share a stream driver selected by sel.
module tb_instr_mem_loader;

  // ---------------- clock / reset / shared stimulus ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       sel;

  always #5 clk = ~clk;

  // ---------------- instance A: ADDR_WIDTH = 8 ----------------
  logic        rdy_a, we_a, hold_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  wl_a;

  instr_mem_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start & ~sel),
    .byte_i         (byte_in),
    .byte_valid_i   (byte_valid & ~sel),
    .byte_ready_o   (rdy_a),
    .mem_we_o       (we_a),
    .mem_addr_o     (addr_a),
    .mem_data_o     (data_a),
    .cpu_hold_o     (hold_a),
    .busy_o         (busy_a),
    .done_o         (done_a),
    .error_o        (err_a),
    .words_loaded_o (wl_a)
  );

  // ---------------- instance B: ADDR_WIDTH = 2 ----------------
  logic        rdy_b, we_b, hold_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  wl_b;

  instr_mem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start & sel),
    .byte_i         (byte_in),
    .byte_valid_i   (byte_valid & sel),
    .byte_ready_o   (rdy_b),
    .mem_we_o       (we_b),
    .mem_addr_o     (addr_b),
    .mem_data_o     (data_b),
    .cpu_hold_o     (hold_b),
    .busy_o         (busy_b),
    .done_o         (done_b),
    .error_o        (err_b),
    .words_loaded_o (wl_b)
  );

  // Outputs of the selected instance, zero-extended to the wide widths.
  logic        rdy, we, hold, busy, done, err;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [8:0]  wl;

  assign rdy  = sel ? rdy_b  : rdy_a;
  assign we   = sel ? we_b   : we_a;
  assign hold = sel ? hold_b : hold_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign err  = sel ? err_b  : err_a;
  assign addr = sel ? {6'd0, addr_b} : addr_a;
  assign data = sel ? data_b : data_a;
  assign wl   = sel ? {6'd0, wl_b}   : wl_a;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [39:0] exp_q[$];     // {addr, data} of each expected write
  logic [7:0]  stream_q[$];  // bytes still to be sent

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write of the selected instance must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset && we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {24'd0, addr, data}, 64'd0);
      end else begin
        check_eq("mem_write", {24'd0, addr, data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!reset && done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream_q.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
  endtask

  // Send one byte after gap idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (rdy) begin
        tick();
        byte_valid = 1'b0;
        return;
      end
      tick();
    end
    byte_valid = 1'b0;
    check_eq("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_bytes(input int count, input int max_gap);
    for (int i = 0; i < count && stream_q.size() > 0; i++)
      send_byte(stream_q.pop_front(), $urandom_range(0, max_gap));
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 50; n++) begin
      if (done) return;
      tick();
    end
    check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {45'd0, rdy, we, hold, busy, done, err, wl, addr, data != 32'd0},
             64'd0);
  endtask

  // Three-word image shared by several tests.
  task automatic queue_image3(input logic [7:0] gap_unused);
    stream_q.delete();
    push_word(32'd3);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    push_word(32'h0000_0133);
    expect_write(8'd0, 32'h0000_0013);
    expect_write(8'd1, 32'h0010_0093);
    expect_write(8'd2, 32'h0000_0133);
    if (gap_unused != 8'd0) stream_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0; sel = 1'b0;
    repeat (3) tick();

    // Reset state of both instances.
    check_all_zero("reset_a");
    sel = 1'b1; #1;
    check_all_zero("reset_b");
    sel = 1'b0;
    reset = 1'b0;
    tick();

    // Test 1: three-word image, no gaps.
    queue_image3(8'd0);
    d0 = done_cnt;
    pulse_start();
    check_eq("t1_hold_rise", {63'd0, hold}, 64'd1);
    check_eq("t1_busy_rise", {63'd0, busy}, 64'd1);
    send_bytes(16, 0);
    check_eq("t1_we_latency", {63'd0, we}, 64'd1);
    check_eq("t1_ready_in_write", {63'd0, rdy}, 64'd0);
    wait_done("t1_done_timeout");
    check_eq("t1_words", {55'd0, wl}, 64'd3);
    check_eq("t1_hold_at_done", {63'd0, hold}, 64'd1);
    tick();
    check_eq("t1_hold_fall", {63'd0, hold}, 64'd0);
    check_eq("t1_busy_fall", {63'd0, busy}, 64'd0);
    check_eq("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check_eq("t1_exp_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t1_addr_hold", {56'd0, addr}, 64'd2);

    // Test 2: empty image; start pulsed alongside done must be ignored.
    stream_q.delete();
    push_word(32'd0);
    pulse_start();
    send_bytes(4, 0);
    check_eq("t2_done_now", {63'd0, done}, 64'd1);
    check_eq("t2_error", {63'd0, err}, 64'd0);
    check_eq("t2_words", {55'd0, wl}, 64'd0);
    pulse_start();
    check_eq("t2_start_at_done_busy", {63'd0, busy}, 64'd0);
    check_eq("t2_hold_fall", {63'd0, hold}, 64'd0);
    tick();

    // Test 3: four-word memory, header 5 -> error.
    sel = 1'b1;
    stream_q.delete();
    push_word(32'd5);
    pulse_start();
    send_bytes(4, 0);
    check_eq("t3_error", {63'd0, err}, 64'd1);
    check_eq("t3_busy", {63'd0, busy}, 64'd0);
    check_eq("t3_hold", {63'd0, hold}, 64'd0);
    tick();
    check_eq("t3_error_sticky", {63'd0, err}, 64'd1);
    pulse_start();
    check_eq("t3_error_cleared", {63'd0, err}, 64'd0);
    stream_q.delete();
    push_word(32'd0);
    send_bytes(4, 0);
    wait_done("t3_done_timeout");
    tick();

    // Test 4: four-word memory, exactly full.
    stream_q.delete();
    push_word(32'd4);
    push_word(32'hAAAA_0001); expect_write(8'd0, 32'hAAAA_0001);
    push_word(32'hBBBB_0002); expect_write(8'd1, 32'hBBBB_0002);
    push_word(32'hCCCC_0003); expect_write(8'd2, 32'hCCCC_0003);
    push_word(32'hDDDD_0004); expect_write(8'd3, 32'hDDDD_0004);
    pulse_start();
    send_bytes(20, 1);
    wait_done("t4_done_timeout");
    check_eq("t4_words", {55'd0, wl}, 64'd4);
    check_eq("t4_last_addr", {56'd0, addr}, 64'd3);
    check_eq("t4_error", {63'd0, err}, 64'd0);
    check_eq("t4_exp_empty", 64'(exp_q.size()), 64'd0);
    tick();
    sel = 1'b0;

    // Test 5: image of test 1 with random gaps and a stray start mid-DATA.
    queue_image3(8'd0);
    d0 = done_cnt;
    pulse_start();
    send_bytes(9, 3);
    pulse_start();
    check_eq("t5_busy_after_start", {63'd0, busy}, 64'd1);
    send_bytes(7, 3);
    wait_done("t5_done_timeout");
    check_eq("t5_words", {55'd0, wl}, 64'd3);
    tick();
    check_eq("t5_done_once", 64'(done_cnt - d0), 64'd1);
    check_eq("t5_exp_empty", 64'(exp_q.size()), 64'd0);

    // Test 6: reset after two of three words, then a fresh load.
    queue_image3(8'd0);
    void'(exp_q.pop_back());
    pulse_start();
    send_bytes(12, 0);
    tick();
    #1 reset = 1'b1;
    #1 check_all_zero("t6_async_reset");
    tick();
    tick();
    reset = 1'b0;
    check_eq("t6_exp_empty", 64'(exp_q.size()), 64'd0);
    stream_q.delete();
    push_word(32'd1);
    push_word(32'hDEAD_BEEF);
    expect_write(8'd0, 32'hDEAD_BEEF);
    pulse_start();
    send_bytes(8, 0);
    wait_done("t6_done_timeout");
    check_eq("t6_words", {55'd0, wl}, 64'd1);
    tick();
    check_eq("t6_exp_empty_end", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
